// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    LOAD,
    FLUSH,
    DONE,
    ERR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  // The loader takes bytes only while parsing the header or the payload.
  function automatic logic state_accepts(input state_e s);
    return (s == HDR0) || (s == HDR1) || (s == LOAD);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into a little-endian 32-bit word; first byte lands in [7:0].
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  logic [LANE_W-1:0]           lane_q;
  logic [8*BYTES_PER_WORD-1:0] shift_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      lane_q  <= '0;
    end else if (accept_i) begin
      lane_q  <= lane_q + LANE_W'(1);
      shift_q <= {byte_i, shift_q[8*BYTES_PER_WORD-1:8]};
    end
  end

  // The completing byte is merged combinationally so the word is whole on the lane-3 edge.
  assign word_o          = {byte_i, shift_q[8*BYTES_PER_WORD-1:8]};
  assign word_complete_o = accept_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes words to instruction
// memory and holds the core in reset until the last word is committed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int          CNT_W = 8 * HDR_BYTES;
  localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wd_q, wd_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [CNT_W-1:0]    n_full;
  logic                last_word;
  logic [31:0]         packed_word;
  logic                word_complete;

  assign accept    = in_valid && ready_q;
  assign n_full    = {in_data, n_q[7:0]};
  assign last_word = (CNT_W'(word_cnt_q) == (n_q - CNT_W'(1)));

  byte_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .accept_i        (accept && (state_q == LOAD)),
    .clear_i         (state_q != LOAD),
    .byte_i          (in_data),
    .word_o          (packed_word),
    .word_complete_o (word_complete)
  );

  // NOTE: every next-state signal gets a default before the case statement,
  // so no path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      HDR0: begin
        if (accept) begin
          n_d     = {n_q[CNT_W-1:8], in_data};
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          n_d        = n_full;
          word_cnt_d = '0;
          if (n_full == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if ({1'b0, n_full} > DEPTH) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_complete) begin
          we_d   = 1'b1;
          addr_d = word_cnt_q[ADDR_W-1:0];
          wd_d   = packed_word;
          if (last_word) state_d = FLUSH;
          else           word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE, ERR: ;
      default: state_d = HDR0;
    endcase

    ready_d = state_accepts(state_d);
  end

  // NOTE: only control and output registers are reset; there is no storage
  // array here, the instruction memory keeps its contents across resets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HDR0;
      n_q        <= '0;
      word_cnt_q <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = ready_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_wd   = wd_q;
  assign done     = done_q;
  assign core_rst = done_q;
  assign error    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stream-level reference model checked every cycle,
// plus literal expectations on the words captured from the write port.
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic              core_rst;
  logic              done;
  logic              error;

  int errors = 0;
  int checks = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory attached to the write port.
  logic [31:0] mem_tb [DEPTH];
  int          wr_count;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= 0;
      for (int i = 0; i < DEPTH; i++) mem_tb[i] <= 32'h0;
    end else if (mem_we) begin
      mem_tb[mem_addr] <= mem_wd;
      wr_count         <= wr_count + 1;
    end
  end

  // Reference model: counts accepted bytes and derives outputs from stream position.
  logic              exp_ready = 1'b0;
  logic              exp_we    = 1'b0;
  logic [ADDR_W-1:0] exp_addr  = '0;
  logic [31:0]       exp_wd    = 32'h0;
  logic              exp_done  = 1'b0;
  logic              exp_error = 1'b0;

  initial begin
    int          nb;
    int          n;
    int          k;
    logic [31:0] cur;
    bit          stopped;
    bit          pending_done;
    bit          acc;
    nb = 0; n = 0; cur = 0; stopped = 0; pending_done = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        nb = 0; n = 0; cur = 0; stopped = 0; pending_done = 0;
        exp_ready = 0; exp_we = 0; exp_addr = '0; exp_wd = 0;
        exp_done = 0; exp_error = 0;
      end else begin
        acc    = in_valid && exp_ready;
        exp_we = 0;
        if (pending_done) begin
          exp_done     = 1;
          pending_done = 0;
        end
        if (acc) begin
          nb++;
          if (nb == 1) begin
            n = int'(in_data);
          end else if (nb == 2) begin
            n = n + 256 * int'(in_data);
            if (n == 0) begin
              exp_done = 1;
              stopped  = 1;
            end else if (n > DEPTH) begin
              exp_error = 1;
              stopped   = 1;
            end
          end else begin
            k = nb - 3;
            cur[8*(k%4) +: 8] = in_data;
            if (k % 4 == 3) begin
              exp_we   = 1;
              exp_addr = ADDR_W'(k / 4);
              exp_wd   = cur;
              if (k / 4 == n - 1) begin
                stopped      = 1;
                pending_done = 1;
              end
            end
          end
        end
        exp_ready = !stopped;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", in_ready, exp_ready);
      check("mem_we",   mem_we,   exp_we);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wd",   mem_wd,   exp_wd);
      check("done",     done,     exp_done);
      check("core_rst", core_rst, exp_done);
      check("error",    error,    exp_error);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd, input int max_cycles,
                           output bit ok);
    logic r;
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      in_data  = b;
      in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      r        = in_ready;
      @(posedge clk);
      if (in_valid && r) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit rnd, input int gap_at);
    bit ok;
    for (int i = 0; i < s.size(); i++) begin
      if (i == gap_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
      end
      send_byte(s[i], rnd, 200, ok);
      check("byte_accepted", 32'(ok), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] s_a[$];
    logic [7:0] s_big[$];
    bit         ok;

    s_a = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    // Reset values while rst is held low.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    do_reset();

    // Two words, valid held high.
    send_stream(s_a, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("a_word0",  mem_tb[0], 32'h00500013);
    check("a_word1",  mem_tb[1], 32'h00100093);
    check("a_writes", 32'(wr_count), 32'd2);
    check("a_done",   32'(done), 32'd1);
    check("a_ready",  32'(in_ready), 32'd0);

    // Same stream, random valid and a 20-cycle gap mid-word.
    do_reset();
    send_stream(s_a, 1'b1, 4);
    repeat (4) @(negedge clk);
    check("b_word0",  mem_tb[0], 32'h00500013);
    check("b_word1",  mem_tb[1], 32'h00100093);
    check("b_writes", 32'(wr_count), 32'd2);
    check("b_done",   32'(done), 32'd1);

    // Empty program.
    do_reset();
    send_stream('{8'h00, 8'h00}, 1'b0, -1);
    send_byte(8'hAA, 1'b0, 8, ok);
    @(negedge clk);
    in_valid = 1'b0;
    check("n0_no_accept", 32'(ok), 32'd0);
    check("n0_writes",    32'(wr_count), 32'd0);
    check("n0_core_rst",  32'(core_rst), 32'd1);

    // Count one past depth.
    do_reset();
    send_stream('{8'h11, 8'h00}, 1'b0, -1);
    send_byte(8'h55, 1'b0, 8, ok);
    @(negedge clk);
    in_valid = 1'b0;
    check("n17_no_accept", 32'(ok), 32'd0);
    check("n17_error",     32'(error), 32'd1);
    check("n17_core_rst",  32'(core_rst), 32'd0);
    check("n17_writes",    32'(wr_count), 32'd0);

    // Exactly full depth.
    do_reset();
    s_big = '{8'h10, 8'h00};
    for (int j = 0; j < 4 * DEPTH; j++) s_big.push_back(8'(j));
    send_stream(s_big, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("n16_writes", 32'(wr_count), 32'd16);
    check("n16_word0",  mem_tb[0],  32'h03020100);
    check("n16_word15", mem_tb[15], 32'h3F3E3D3C);
    check("n16_done",   32'(done), 32'd1);

    // Reset in the middle of the second word, then a fresh one-word load.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_byte(s_a[i], 1'b0, 200, ok);
      check("mid_byte_accepted", 32'(ok), 32'd1);
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mem_we",   32'(mem_we),   32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_mem_wd",   mem_wd,        32'd0);
    check("mid_rst_ready",    32'(in_ready), 32'd0);
    check("mid_rst_done",     32'(done),     32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    send_stream('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("f_word0",  mem_tb[0], 32'hDEADBEEF);
    check("f_writes", 32'(wr_count), 32'd1);
    check("f_done",   32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
